// File: rtl/ms_uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, legal parameter
// ranges, frame config payload and frame-length helper.
package ms_uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;
    localparam int unsigned OVS_MIN    = 4;
    localparam int unsigned OVS_MAX    = 32;
    localparam int unsigned DBITS_W    = 4;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    typedef struct packed {
        logic [DBITS_W-1:0] dbits;
        logic               par_en;
        logic               par_odd;
        logic               stop2;
    } frame_cfg_t;

    // Frame length in TICKs for a given format.
    function automatic int unsigned frame_ticks(
        input int unsigned ovs,
        input int unsigned dbits,
        input logic        par_en,
        input logic        stop2
    );
        int unsigned p;
        int unsigned s;
        p = par_en ? 32'd1 : 32'd0;
        s = stop2  ? 32'd2 : 32'd1;
        return ovs * (32'd1 + dbits + p + s);
    endfunction

    // Clamp data bits into DATA_W_MIN..data_w and fold parity code 3 into none.
    function automatic frame_cfg_t decode_cfg(
        input logic [DBITS_W-1:0] dbits_in,
        input logic [1:0]         parity,
        input logic               stop2,
        input int unsigned        data_w
    );
        frame_cfg_t c;
        if ((dbits_in >= DBITS_W'(DATA_W_MIN)) && (dbits_in <= DBITS_W'(data_w)))
            c.dbits = dbits_in;
        else
            c.dbits = DBITS_W'(data_w);
        c.par_en  = (parity == PAR_EVEN) || (parity == PAR_ODD);
        c.par_odd = (parity == PAR_ODD);
        c.stop2   = stop2;
        return c;
    endfunction

endpackage

// File: rtl/ms_uart_bit_timer.sv
// Counts baud TICKs and flags the last TICK of each OVS-long bit period.
module ms_uart_bit_timer #(
    parameter int unsigned OVS = 16
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic TICK,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVS - 1);

    logic [CNT_W-1:0] cnt_q;

    // bit_end stays visible on a clr cycle so a back-to-back accept still sees the stop end
    assign bit_end = TICK && !RESETN && (cnt_q == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (RESETN || clr)
            cnt_q <= '0;
        else if (TICK)
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

endmodule

// File: rtl/ms_uart_tx_frame.sv
// Runtime-configurable UART transmitter: start, 5..DATA_W data bits LSB first,
// optional even/odd parity, one or two stop bits, valid/ready payload intake.
module ms_uart_tx_frame
    import ms_uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OVS    = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              TICK,
    input  logic [3:0]        CFG_DBITS,
    input  logic [1:0]        CFG_PARITY,
    input  logic              CFG_STOP2,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              DOUT,
    output logic              BUSY,
    output logic              DONE
);

    uart_state_e         state_q;
    uart_state_e         state_nx;
    frame_cfg_t          cfg_q;
    frame_cfg_t          cfg_in;
    logic [DATA_W-1:0]   shreg_q;
    logic [DBITS_W-1:0]  bit_idx_q;
    logic                par_acc_q;
    logic [DATA_W-1:0]   din_mask;
    logic                par_in;
    logic                bit_end;
    logic                accept;
    logic                last_data;
    logic                frame_end;

    assign cfg_in = decode_cfg(CFG_DBITS, CFG_PARITY, CFG_STOP2, DATA_W);

    // Mask wraps to all ones when dbits equals DATA_W
    assign din_mask  = (DATA_W'(1) << cfg_in.dbits) - DATA_W'(1);
    assign par_in    = ^(DIN & din_mask);

    assign accept    = DIN_VALID && DIN_READY;
    assign last_data = (bit_idx_q == (cfg_q.dbits - DBITS_W'(1)));
    assign frame_end = (state_q == ST_STOP) && bit_end &&
                       (bit_idx_q == DBITS_W'(cfg_q.stop2));

    ms_uart_bit_timer #(
        .OVS(OVS)
    ) u_bit_timer (
        .CLK    (CLK),
        .RESETN (RESETN),
        .TICK   (TICK),
        .clr    (accept),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RESETN)
            state_q <= ST_IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_nx = ST_START;
            ST_START:  if (bit_end) state_nx = ST_DATA;
            ST_DATA:   if (bit_end && last_data)
                           state_nx = cfg_q.par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nx = ST_STOP;
            ST_STOP:   if (frame_end) state_nx = accept ? ST_START : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        DOUT      = 1'b1;
        BUSY      = 1'b1;
        DONE      = frame_end;
        DIN_READY = 1'b0;
        case (state_q)
            ST_IDLE: begin
                BUSY      = 1'b0;
                DIN_READY = !RESETN;
            end
            ST_START:  DOUT = 1'b0;
            ST_DATA:   DOUT = shreg_q[0];
            ST_PARITY: DOUT = par_acc_q ^ cfg_q.par_odd;
            ST_STOP:   DIN_READY = frame_end;
            default:   DOUT = 1'b1;
        endcase
    end

    // Payload, format and bit index; accept takes priority over bit sequencing
    always_ff @(posedge CLK) begin
        if (RESETN) begin
            cfg_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            par_acc_q <= 1'b0;
        end else if (accept) begin
            cfg_q     <= cfg_in;
            shreg_q   <= DIN;
            bit_idx_q <= '0;
            par_acc_q <= par_in;
        end else if (bit_end) begin
            case (state_q)
                ST_DATA: begin
                    shreg_q   <= shreg_q >> 1;
                    bit_idx_q <= last_data ? '0 : bit_idx_q + DBITS_W'(1);
                end
                ST_STOP:  bit_idx_q <= bit_idx_q + DBITS_W'(1);
                default:  bit_idx_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_uart_tx_frame.sv
// Directed bench for ms_uart_tx_frame: table of single frames plus
// hand-written back-to-back and mid-frame reset sequences.
module tb_ms_uart_tx_frame;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OVS    = 16;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic              TICK;
    logic [3:0]        CFG_DBITS;
    logic [1:0]        CFG_PARITY;
    logic              CFG_STOP2;
    logic [DATA_W-1:0] DIN;
    logic              DIN_VALID;
    logic              DIN_READY;
    logic              DOUT;
    logic              BUSY;
    logic              DONE;

    ms_uart_tx_frame #(.DATA_W(DATA_W), .OVS(OVS)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .TICK      (TICK),
        .CFG_DBITS (CFG_DBITS),
        .CFG_PARITY(CFG_PARITY),
        .CFG_STOP2 (CFG_STOP2),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .DOUT      (DOUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pay_q[$];

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [3:0] dbits;
        logic [1:0] par;
        logic       stop2;
        string      exp;     // line levels, one char per bit period, first sent first
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Offer payloads from pay_q with fixed config and follow nframes back-to-back frames
    task automatic run_frames(input string name, input logic [3:0] dbits, input logic [1:0] par,
                              input logic stop2, input string exp, input int nframes);
        int   flen_ticks;
        int   tick_cnt;
        int   frames_done;
        int   limit;
        int   bit_no;
        logic acc_pending;
        logic exp_done;
        logic finished;
        flen_ticks  = (exp.len() / nframes) * OVS;
        tick_cnt    = 0;
        frames_done = 0;
        finished    = 1'b0;
        limit       = nframes * flen_ticks * 2 + 20;
        @(negedge CLK);
        CFG_DBITS  = dbits;
        CFG_PARITY = par;
        CFG_STOP2  = stop2;
        DIN        = pay_q.pop_front();
        DIN_VALID  = 1'b1;
        TICK       = 1'b0;
        #1;
        check({name, " idle ready"}, 32'(DIN_READY), 32'd1);
        check({name, " idle dout"},  32'(DOUT),      32'd1);
        check({name, " idle busy"},  32'(BUSY),      32'd0);
        acc_pending = 1'b1;
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            @(negedge CLK);
            if (acc_pending) begin
                if (pay_q.size() != 0) begin
                    DIN = pay_q.pop_front();
                end else begin
                    DIN_VALID  = 1'b0;
                    DIN        = 8'h00;
                    CFG_DBITS  = 4'd5;
                    CFG_PARITY = 2'd2;
                    CFG_STOP2  = ~stop2;
                end
            end
            TICK = cyc[0];
            #1;
            if (TICK) tick_cnt++;
            exp_done = TICK && ((tick_cnt % flen_ticks) == 0);
            check({name, " busy"},  32'(BUSY),      32'd1);
            check({name, " done"},  32'(DONE),      32'(exp_done));
            check({name, " ready"}, 32'(DIN_READY), 32'(exp_done));
            if (TICK && (((tick_cnt - 1) % OVS) == OVS / 2)) begin
                bit_no = (tick_cnt - 1) / OVS;
                check($sformatf("%s bit%0d", name, bit_no), 32'(DOUT),
                      (exp[bit_no] == 8'h31) ? 32'd1 : 32'd0);
            end
            acc_pending = DIN_VALID && DIN_READY;
            if (exp_done) begin
                frames_done++;
                if (frames_done == nframes) finished = 1'b1;
            end
        end
        if (!finished) check({name, " timeout"}, 32'(frames_done), 32'(nframes));
        @(negedge CLK);
        TICK = 1'b0;
        #1;
        check({name, " end busy"},  32'(BUSY),      32'd0);
        check({name, " end dout"},  32'(DOUT),      32'd1);
        check({name, " end done"},  32'(DONE),      32'd0);
        check({name, " end ready"}, 32'(DIN_READY), 32'd1);
    endtask

    initial begin
        int   tick_cnt;
        logic reached;

        vecs[0] = '{"8N1 A5",  8'hA5, 4'd8,  2'd0, 1'b0, "0101001011"};
        vecs[1] = '{"8E1 A5",  8'hA5, 4'd8,  2'd1, 1'b0, "01010010101"};
        vecs[2] = '{"8O1 A5",  8'hA5, 4'd8,  2'd2, 1'b0, "01010010111"};
        vecs[3] = '{"8E1 07",  8'h07, 4'd8,  2'd1, 1'b0, "01110000011"};
        vecs[4] = '{"7N2 C1",  8'hC1, 4'd7,  2'd0, 1'b1, "0100000111"};
        vecs[5] = '{"clamp 5A", 8'h5A, 4'd3, 2'd3, 1'b0, "0010110101"};
        vecs[6] = '{"5O1 FF",  8'hFF, 4'd5,  2'd2, 1'b0, "01111101"};
        vecs[7] = '{"15E2 3C", 8'h3C, 4'd15, 2'd1, 1'b1, "000111100011"};

        RESETN     = 1'b1;
        TICK       = 1'b1;
        CFG_DBITS  = 4'd8;
        CFG_PARITY = 2'd0;
        CFG_STOP2  = 1'b0;
        DIN        = 8'h00;
        DIN_VALID  = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("reset ready", 32'(DIN_READY), 32'd0);
        check("reset dout",  32'(DOUT),      32'd1);
        check("reset busy",  32'(BUSY),      32'd0);
        check("reset done",  32'(DONE),      32'd0);
        @(negedge CLK);
        RESETN    = 1'b0;
        TICK      = 1'b0;
        DIN_VALID = 1'b0;
        #1;
        check("release ready", 32'(DIN_READY), 32'd1);

        foreach (vecs[i]) begin
            pay_q = {vecs[i].din};
            run_frames(vecs[i].name, vecs[i].dbits, vecs[i].par, vecs[i].stop2, vecs[i].exp, 1);
        end

        pay_q = {8'h11, 8'h22, 8'h33};
        run_frames("b2b", 4'd8, 2'd0, 1'b0, {"0100010001", "0010001001", "0110011001"}, 3);

        // Reset in the middle of data bit 3, then a clean frame
        @(negedge CLK);
        CFG_DBITS  = 4'd8;
        CFG_PARITY = 2'd0;
        CFG_STOP2  = 1'b0;
        DIN        = 8'h00;
        DIN_VALID  = 1'b1;
        TICK       = 1'b0;
        tick_cnt   = 0;
        reached    = 1'b0;
        for (int cyc = 0; cyc < 400 && !reached; cyc++) begin
            @(negedge CLK);
            DIN_VALID = 1'b0;
            TICK      = cyc[0];
            #1;
            if (TICK) tick_cnt++;
            if (tick_cnt == 4 * OVS + 5) reached = 1'b1;
        end
        check("rst reach bit3", 32'(reached), 32'd1);
        check("rst data bit3",  32'(DOUT),    32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        TICK   = 1'b1;
        #1;
        check("rst mid ready", 32'(DIN_READY), 32'd0);
        check("rst mid done",  32'(DONE),      32'd0);
        @(negedge CLK);
        RESETN = 1'b0;
        TICK   = 1'b0;
        #1;
        check("rst after dout",  32'(DOUT),      32'd1);
        check("rst after busy",  32'(BUSY),      32'd0);
        check("rst after done",  32'(DONE),      32'd0);
        check("rst after ready", 32'(DIN_READY), 32'd1);

        pay_q = {8'hA5};
        run_frames("post rst", 4'd8, 2'd1, 1'b0, "01010010101", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
